// File: rtl/pattern_serializer_if.sv
// Handshake and serial-output bundle between a pattern source and the
// pattern_serializer. The source side uses the master modport.
interface pattern_serializer_if #(
  parameter int WIDTH = 8
);
  logic             Load;
  logic [WIDTH-1:0] Data;
  logic             Abort;
  logic             Ready;
  logic             w;
  logic             Active;
  logic             Done;

  modport master (
    output Load, Data, Abort,
    input  Ready, w, Active, Done
  );

  modport slave (
    input  Load, Data, Abort,
    output Ready, w, Active, Done
  );
endinterface

// File: rtl/pattern_serializer.sv
// Parallel-to-serial stimulus stage: accepts a WIDTH-bit pattern and drives it
// MSB first on w, holding each bit for BIT_CYCLES clocks. w is forced low
// whenever no pattern is in flight, so the downstream two-ones detector always
// sees at least one 0 between patterns.
module pattern_serializer #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 1
) (
  input logic                  Clock,
  input logic                  Resetn,
  pattern_serializer_if.slave  bus
);

  localparam int BW = $clog2(WIDTH);
  localparam int HW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  localparam logic [BW-1:0] BCNT_LOAD = BW'(WIDTH - 1);
  localparam logic [HW-1:0] HCNT_LOAD = HW'(BIT_CYCLES - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sreg, sreg_nx;
  logic [BW-1:0]    bcnt, bcnt_nx;
  logic [HW-1:0]    hcnt, hcnt_nx;
  logic             done, done_nx;

  // State and datapath registers; reset clears everything and wins over Load/Abort.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state <= IDLE;
      sreg  <= '0;
      bcnt  <= '0;
      hcnt  <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      sreg  <= sreg_nx;
      bcnt  <= bcnt_nx;
      hcnt  <= hcnt_nx;
      done  <= done_nx;
    end
  end

  // Next-state logic: Abort first, then bit hold, then bit advance, then finish.
  always_comb begin
    state_nx = state;
    sreg_nx  = sreg;
    bcnt_nx  = bcnt;
    hcnt_nx  = hcnt;
    done_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        // Abort is not looked at here, so Load wins when both are high.
        if (bus.Load) begin
          sreg_nx  = bus.Data;
          bcnt_nx  = BCNT_LOAD;
          hcnt_nx  = HCNT_LOAD;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.Abort) begin
          state_nx = IDLE;
        end else if (hcnt != '0) begin
          hcnt_nx = hcnt - 1'b1;
        end else if (bcnt != '0) begin
          sreg_nx = {sreg[WIDTH-2:0], 1'b0};
          bcnt_nx = bcnt - 1'b1;
          hcnt_nx = HCNT_LOAD;
        end else begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decode registered state only; no input reaches an output combinationally.
  assign bus.Ready  = (state == IDLE);
  assign bus.Active = (state == SHIFT);
  assign bus.w      = (state == SHIFT) && sreg[WIDTH-1];
  assign bus.Done   = done;

endmodule

// File: tb/tb_pattern_serializer.sv
// Bench for pattern_serializer: one instance with single-cycle bits, one with
// three-cycle bits. Per-cycle vector table plus hand-written sequences.
module tb_pattern_serializer;

  logic Clock  = 1'b0;
  logic Resetn = 1'b0;

  pattern_serializer_if #(.WIDTH(8)) ifa ();
  pattern_serializer_if #(.WIDTH(8)) ifb ();

  pattern_serializer #(.WIDTH(8), .BIT_CYCLES(1)) dut_a (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (ifa)
  );

  pattern_serializer #(.WIDTH(8), .BIT_CYCLES(3)) dut_b (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (ifb)
  );

  always #5 Clock = ~Clock;

  int n_pass = 0;
  int n_tot  = 0;

  typedef struct {
    logic       load;
    logic [7:0] data;
    logic       abort;
    logic       ready;
    logic       w;
    logic       active;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic ld, input logic [7:0] d, input logic ab,
                     input logic rdy, input logic ww, input logic act, input logic dn);
    vec_t v;
    v.load = ld; v.data = d; v.abort = ab;
    v.ready = rdy; v.w = ww; v.active = act; v.done = dn;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic act, input logic exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic chk_a(input string nm, input logic rdy, input logic ww,
                       input logic act, input logic dn);
    chk({nm, ".Ready"},  ifa.Ready,  rdy);
    chk({nm, ".w"},      ifa.w,      ww);
    chk({nm, ".Active"}, ifa.Active, act);
    chk({nm, ".Done"},   ifa.Done,   dn);
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    logic [7:0] pat;
    int         pos;

    ifa.Load = 1'b0; ifa.Data = '0; ifa.Abort = 1'b0;
    ifb.Load = 1'b0; ifb.Data = '0; ifb.Abort = 1'b0;

    // Reset held for two edges, then five idle cycles on both instances.
    Resetn = 1'b0;
    step();
    step();
    Resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_a($sformatf("idle_a%0d", i), 1'b1, 1'b0, 1'b0, 1'b0);
      chk($sformatf("idle_b%0d.Ready", i), ifb.Ready, 1'b1);
      chk($sformatf("idle_b%0d.w", i), ifb.w, 1'b0);
      chk($sformatf("idle_b%0d.Done", i), ifb.Done, 1'b0);
    end

    // Basic 0x6E shift with an ignored mid-pattern Load, then idle Abort
    // and simultaneous Load/Abort in idle.
    add(1, 8'h6E, 0, 0, 0, 1, 0);
    add(0, 8'h00, 0, 0, 1, 1, 0);
    add(1, 8'h00, 0, 0, 1, 1, 0);
    add(0, 8'h00, 0, 0, 0, 1, 0);
    add(0, 8'h00, 0, 0, 1, 1, 0);
    add(0, 8'h00, 0, 0, 1, 1, 0);
    add(0, 8'h00, 0, 0, 1, 1, 0);
    add(0, 8'h00, 0, 0, 0, 1, 0);
    add(0, 8'h00, 0, 1, 0, 0, 1);
    add(0, 8'h00, 1, 1, 0, 0, 0);
    add(1, 8'h80, 1, 0, 1, 1, 0);
    add(0, 8'h00, 1, 1, 0, 0, 0);
    add(0, 8'h00, 0, 1, 0, 0, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      ifa.Load = vecs[i].load; ifa.Data = vecs[i].data; ifa.Abort = vecs[i].abort;
      step();
      chk_a($sformatf("vec%0d", i), vecs[i].ready, vecs[i].w, vecs[i].active, vecs[i].done);
    end
    ifa.Load = 1'b0; ifa.Abort = 1'b0;

    // Bit hold on the three-cycle instance: 0x81.
    ifb.Load = 1'b1; ifb.Data = 8'h81;
    step();
    ifb.Load = 1'b0; ifb.Data = 8'h00;
    for (int c = 1; c <= 26; c++) begin
      logic ew;
      if (c <= 3 || (c >= 22 && c <= 24)) ew = 1'b1; else ew = 1'b0;
      chk($sformatf("hold_c%0d.w", c), ifb.w, ew);
      chk($sformatf("hold_c%0d.Active", c), ifb.Active, (c <= 24));
      chk($sformatf("hold_c%0d.Done", c), ifb.Done, (c == 25));
      chk($sformatf("hold_c%0d.Ready", c), ifb.Ready, (c > 24));
      if (c < 26) step();
    end

    // Back-to-back with Load held; Data is only valid at the accepting edges.
    ifa.Load = 1'b1; ifa.Data = 8'hFF;
    pos = -1;
    for (int c = 1; c <= 27; c++) begin
      step();
      pos = (c - 1) % 9;
      chk_a($sformatf("b2b_c%0d", c), (pos == 8), (pos < 8), (pos < 8), (pos == 8));
      ifa.Data = (pos == 8) ? 8'hFF : 8'h00;
    end
    ifa.Load = 1'b0;
    step();
    step();
    chk_a("b2b_end", 1'b1, 1'b0, 1'b0, 1'b0);

    // Abort after four bits of 0xAA, then a clean 0x0F.
    ifa.Load = 1'b1; ifa.Data = 8'hAA;
    step();
    ifa.Load = 1'b0; ifa.Data = 8'h00;
    pat = 8'hAA;
    for (int i = 0; i < 4; i++) begin
      chk_a($sformatf("abort_bit%0d", i), 1'b0, pat[7-i], 1'b1, 1'b0);
      if (i < 3) step();
    end
    ifa.Abort = 1'b1;
    step();
    ifa.Abort = 1'b0;
    chk_a("abort_next", 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk_a("abort_nodone", 1'b1, 1'b0, 1'b0, 1'b0);
    ifa.Load = 1'b1; ifa.Data = 8'h0F;
    step();
    ifa.Load = 1'b0; ifa.Data = 8'h00;
    pat = 8'h0F;
    for (int i = 0; i < 8; i++) begin
      chk_a($sformatf("post_abort_bit%0d", i), 1'b0, pat[7-i], 1'b1, 1'b0);
      step();
    end
    chk_a("post_abort_done", 1'b1, 1'b0, 1'b0, 1'b1);

    // Reset mid-pattern with Load held high throughout.
    step();
    ifa.Load = 1'b1; ifa.Data = 8'hFF;
    step();
    for (int i = 0; i < 2; i++) begin
      chk_a($sformatf("rst_bit%0d", i), 1'b0, 1'b1, 1'b1, 1'b0);
      step();
    end
    chk_a("rst_bit2", 1'b0, 1'b1, 1'b1, 1'b0);
    Resetn = 1'b0;
    step();
    chk_a("rst_mid0", 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk_a("rst_mid1", 1'b1, 1'b0, 1'b0, 1'b0);
    Resetn = 1'b1;
    step();
    chk_a("rst_reload", 1'b0, 1'b1, 1'b1, 1'b0);
    ifa.Load = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/pattern_serializer.md
# pattern_serializer

Parallel-to-serial stimulus stage that drives the one-bit `w` input of the two-consecutive-ones sequence detector. It accepts a WIDTH-bit pattern on a load handshake and shifts it out MSB first, holding each bit for BIT_CYCLES clocks. When no pattern is in flight it drives `w` to 0, which returns the downstream detector to its idle state between patterns. Both blocks share one clock domain.

## Interface
- WIDTH, 8: pattern length in bits; must be ≥ 2.
- BIT_CYCLES, 1: clocks each bit is held on `w`; must be ≥ 1.
- Clock  in  1  rising-edge clock shared with the detector.
- Resetn  in  1  synchronous, active-low reset, sampled on the rising edge of Clock.
- Load  in  1  load request; sampled only while Ready=1.
- Data  in  WIDTH  pattern captured when Load is accepted.
- Abort  in  1  synchronous cancel of an in-flight pattern.
- Ready  out  1  high when idle and able to accept Load.
- w  out  1  serial bit to the detector; 0 when not shifting.
- Active  out  1  high in every cycle in which w carries a pattern bit.
- Done  out  1  one-cycle pulse after the last bit of a completed pattern.

## Operation
- Two states: IDLE and SHIFT. Registers: shift register sreg[WIDTH-1:0], bit counter bcnt (counts WIDTH-1 down to 0), hold counter hcnt (counts BIT_CYCLES-1 down to 0), registered Done flag.
- Outputs by state:
  - IDLE: Ready=1, w=0, Active=0.
  - SHIFT: Ready=0, w=sreg[WIDTH-1], Active=1.
  - Done is a register and is independent of state decode.
- IDLE with Load=1 at an edge:
  - sreg<=Data, bcnt<=WIDTH-1, hcnt<=BIT_CYCLES-1; go to SHIFT.
  - Load=0 keeps the block in IDLE.
- SHIFT, evaluated each edge in this priority:
  1. Abort=1: go to IDLE. Done stays 0. sreg contents are don't-care.
  2. hcnt≠0: hcnt<=hcnt-1.
  3. hcnt=0 and bcnt≠0: sreg<=sreg<<1 (zero fill), bcnt<=bcnt-1, hcnt<=BIT_CYCLES-1.
  4. hcnt=0 and bcnt=0: go to IDLE, Done<=1.
- Done<=0 on every other edge, so it is always exactly one cycle wide.
- Load while in SHIFT is ignored and not queued. Data is sampled only at the accepting edge; later changes to Data have no effect.
- Abort while in IDLE has no effect.
- Abort and Load high together in IDLE: Load wins, because Abort is only evaluated in SHIFT.
- Reset: Resetn=0 at an edge forces IDLE, Done=0, and clears sreg, bcnt and hcnt. This overrides Load and Abort, and applies mid-pattern as well. Outputs are undefined before the first edge with Resetn=0.
- Counter widths: bcnt uses clog2(WIDTH) bits and hcnt uses max(1, clog2(BIT_CYCLES)) bits. Neither counter wraps, because each is reloaded before it would underflow.

## Timing
- Load accepted at edge k:
  - w=Data[WIDTH-1] during cycles k+1 … k+BIT_CYCLES.
  - Bit i (MSB = bit 0 of the sequence) is driven during cycles k+1+i·BIT_CYCLES … k+(i+1)·BIT_CYCLES.
- The last bit ends in cycle k+WIDTH·BIT_CYCLES. In cycle k+WIDTH·BIT_CYCLES+1: Done=1, Ready=1, w=0, Active=0.
- Back-to-back patterns:
  - A Load during the Done cycle is accepted.
  - The minimum gap between patterns is one cycle with w=0. This guarantees the detector sees a 0 between patterns.
  - Throughput is WIDTH·BIT_CYCLES+1 cycles per pattern.
- Abort at edge j: w=0, Active=0, Ready=1 from cycle j+1. Load is accepted at edge j+1 at the earliest.
- All outputs are registered-state decodes. There is no combinational path from Load, Data or Abort to any output.

## Test plan
- Reset then idle: hold Resetn=0 for 2 edges, then release with Load=0 for 5 cycles → Ready=1, w=0, Active=0, Done=0 throughout.
- Basic shift (WIDTH=8, BIT_CYCLES=1): Data=8'b0110_1110, Load at edge k → w over cycles k+1..k+8 = 0,1,1,0,1,1,1,0; Active=1 for exactly 8 cycles; Done=1 only in cycle k+9; Ready=0 during cycles k+1..k+8.
- Bit hold (BIT_CYCLES=3): Data=8'b1000_0001 → w=1 for 3 cycles, then 0 for 18 cycles, then 1 for 3 cycles; Done in cycle k+25.
- Back-to-back and ignored load: assert Load continuously with Data=8'hFF → each burst is eight 1s; bursts are separated by exactly one w=0 cycle, which coincides with the Done cycle; Load pulses during SHIFT do not change the output.
- Abort mid-pattern: Data=8'hAA, Abort at the 4th bit edge → w=0 and Ready=1 in the next cycle; no Done pulse; a following Load of 8'h0F shifts out correctly.
- Reset mid-pattern: Resetn=0 at the 3rd bit edge with Load=1 held → next cycle is IDLE with w=0 and no Done; the pattern is not reloaded until Resetn=1.
